// File: rtl/matrix_transpose_stream_pkg.sv
// ---------------------------------------------------------------------------
// mt_pkg
// Shared types and helpers for the streaming matrix transpose engine.
//   mt_mode_e : per-matrix output ordering (row passthrough or column transpose)
//   mt_elem() : extracts element e of width w from a packed row
// ---------------------------------------------------------------------------
package mt_pkg;

    typedef enum logic {
        MT_PASS      = 1'b0,
        MT_TRANSPOSE = 1'b1
    } mt_mode_e;

    // Widest packed row mt_elem() can handle; DIM*DATA_WIDTH must not exceed it.
    localparam int MT_ROW_W_MAX = 4096;

    // Returns the row shifted so element e sits in the LSBs; the caller
    // narrows the result to its own element width with a size cast.
    function automatic logic [MT_ROW_W_MAX-1:0] mt_elem(
        input logic [MT_ROW_W_MAX-1:0] row,
        input int                      e,
        input int                      w
    );
        return row >> (e * w);
    endfunction

endpackage

// File: rtl/matrix_transpose_stream_if.sv
// ---------------------------------------------------------------------------
// mt_stream_if
// Row-in / beat-out handshake bundle of matrix_transpose_stream.
//   master : upstream producer and downstream consumer side
//            (drives in_valid, in_mode, in_row, out_ready)
//   slave  : the transpose engine
//            (drives in_ready, out_valid, out_row, out_last, out_mode)
// Element e of a row lives at bits [e*DATA_WIDTH +: DATA_WIDTH].
// ---------------------------------------------------------------------------
interface mt_stream_if #(
    parameter int DATA_WIDTH = 64,
    parameter int DIM        = 8
);
    logic                      in_valid;
    logic                      in_ready;
    logic                      in_mode;
    logic [DIM*DATA_WIDTH-1:0] in_row;
    logic                      out_valid;
    logic                      out_ready;
    logic [DIM*DATA_WIDTH-1:0] out_row;
    logic                      out_last;
    logic                      out_mode;

    modport master (
        output in_valid, in_mode, in_row, out_ready,
        input  in_ready, out_valid, out_row, out_last, out_mode
    );

    modport slave (
        input  in_valid, in_mode, in_row, out_ready,
        output in_ready, out_valid, out_row, out_last, out_mode
    );
endinterface

// File: rtl/matrix_transpose_stream_bank.sv
// ---------------------------------------------------------------------------
// mt_bank
// One DIM x DIM element store of the ping-pong pair.
//   clk     : clock
//   i_we    : write enable, stores i_wdata as row i_wrow
//   i_wrow  : row index being written
//   i_wdata : packed row to store
//   i_ridx  : beat index being read
//   i_mode  : MT_PASS reads row i_ridx, MT_TRANSPOSE reads column i_ridx
//   o_rdata : combinational read data, same packing as i_wdata
// Contents are deliberately not reset; the owner tracks validity.
// ---------------------------------------------------------------------------
module mt_bank
    import mt_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int DIM        = 8,
    localparam int CNT_W     = $clog2(DIM),
    localparam int ROW_W     = DIM * DATA_WIDTH
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [CNT_W-1:0] i_wrow,
    input  logic [ROW_W-1:0] i_wdata,
    input  logic [CNT_W-1:0] i_ridx,
    input  mt_mode_e         i_mode,
    output logic [ROW_W-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DIM][DIM];

    // Row write: unpack the incoming row into its DIM element slots.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int e = 0; e < DIM; e++) begin
                r_mem[i_wrow][e] <= DATA_WIDTH'(mt_elem(MT_ROW_W_MAX'(i_wdata), e, DATA_WIDTH));
            end
        end
    end

    // Read mux: the same index selects a row or a column depending on mode.
    always_comb begin
        o_rdata = '0;
        for (int e = 0; e < DIM; e++) begin
            if (i_mode == MT_TRANSPOSE) begin
                o_rdata[e*DATA_WIDTH +: DATA_WIDTH] = r_mem[e][i_ridx];
            end else begin
                o_rdata[e*DATA_WIDTH +: DATA_WIDTH] = r_mem[i_ridx][e];
            end
        end
    end

endmodule

// File: rtl/matrix_transpose_stream.sv
// ---------------------------------------------------------------------------
// matrix_transpose_stream
// Double-buffered DIM x DIM transpose engine between the memory-group fabric
// and the PE array. One row is written per accepted input beat; once a bank
// holds a full matrix it is drained one beat per output transfer, either
// transposed (columns) or unchanged (rows), as chosen by in_mode on row 0.
//   clk         : clock
//   rst         : synchronous, active-high reset
//   bus         : mt_stream_if.slave handshake bundle (rows in, beats out)
//   mat_count   : matrices fully drained        (MT_STREAM_STATS_EN only)
//   stall_count : cycles with in_valid && !in_ready (MT_STREAM_STATS_EN only)
// Optional feature macro: MT_STREAM_STATS_EN adds the two statistic counters.
// ---------------------------------------------------------------------------
module matrix_transpose_stream
    import mt_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int DIM        = 8
) (
    input  logic        clk,
    input  logic        rst,
    mt_stream_if.slave  bus
`ifdef MT_STREAM_STATS_EN
    ,
    output logic [31:0] mat_count,
    output logic [31:0] stall_count
`endif
);

    localparam int              CNT_W    = $clog2(DIM);
    localparam int              ROW_W    = DIM * DATA_WIDTH;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DIM - 1);

    logic [1:0]       r_full;
    mt_mode_e         r_mode [2];
    logic             r_wb;
    logic             r_rb;
    logic [CNT_W-1:0] r_wrCnt;
    logic [CNT_W-1:0] r_rdCnt;

    logic             w_inReady;
    logic             w_inFire;
    logic             w_outValid;
    logic             w_outFire;
    logic             w_wrLast;
    logic             w_rdLast;
    logic [ROW_W-1:0] w_bankData0;
    logic [ROW_W-1:0] w_bankData1;

    // A bank accepts rows only while it is empty; full means "owned by the reader".
    assign w_inReady  = !rst && !r_full[r_wb];
    assign w_inFire   = bus.in_valid && w_inReady;
    assign w_outValid = r_full[r_rb];
    assign w_outFire  = w_outValid && bus.out_ready;
    assign w_wrLast   = (r_wrCnt == LAST_IDX);
    assign w_rdLast   = (r_rdCnt == LAST_IDX);

    assign bus.in_ready  = w_inReady;
    assign bus.out_valid = w_outValid;

    mt_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .DIM        (DIM)
    ) u_bank0 (
        .clk     (clk),
        .i_we    (w_inFire && !r_wb),
        .i_wrow  (r_wrCnt),
        .i_wdata (bus.in_row),
        .i_ridx  (r_rdCnt),
        .i_mode  (r_mode[0]),
        .o_rdata (w_bankData0)
    );

    mt_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .DIM        (DIM)
    ) u_bank1 (
        .clk     (clk),
        .i_we    (w_inFire && r_wb),
        .i_wrow  (r_wrCnt),
        .i_wdata (bus.in_row),
        .i_ridx  (r_rdCnt),
        .i_mode  (r_mode[1]),
        .o_rdata (w_bankData1)
    );

    // Pointer and flag update. When a write completes on bank wb and a read
    // completes on bank rb in the same cycle they are different banks (the
    // writer only owns an empty bank, the reader only a full one), so both
    // full-flag updates land independently.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full    <= '0;
            r_mode[0] <= MT_PASS;
            r_mode[1] <= MT_PASS;
            r_wb      <= 1'b0;
            r_rb      <= 1'b0;
            r_wrCnt   <= '0;
            r_rdCnt   <= '0;
        end else begin
            if (w_inFire) begin
                if (r_wrCnt == '0) begin
                    r_mode[r_wb] <= mt_mode_e'(bus.in_mode);
                end
                if (w_wrLast) begin
                    r_full[r_wb] <= 1'b1;
                    r_wb         <= ~r_wb;
                    r_wrCnt      <= '0;
                end else begin
                    r_wrCnt <= r_wrCnt + 1'b1;
                end
            end
            if (w_outFire) begin
                if (w_rdLast) begin
                    r_full[r_rb] <= 1'b0;
                    r_rb         <= ~r_rb;
                    r_rdCnt      <= '0;
                end else begin
                    r_rdCnt <= r_rdCnt + 1'b1;
                end
            end
        end
    end

    // Output beat: zeroed when nothing is valid so idle cycles are clean.
    // While stalled the selected bank, mode and counter cannot change, so
    // the beat holds by construction.
    always_comb begin
        bus.out_row  = '0;
        bus.out_last = 1'b0;
        bus.out_mode = 1'b0;
        if (w_outValid) begin
            bus.out_row  = r_rb ? w_bankData1 : w_bankData0;
            bus.out_last = w_rdLast;
            bus.out_mode = r_mode[r_rb];
        end
    end

`ifdef MT_STREAM_STATS_EN
    // Free-running statistics; both wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            mat_count   <= '0;
            stall_count <= '0;
        end else begin
            if (w_outFire && w_rdLast) begin
                mat_count <= mat_count + 32'd1;
            end
            if (bus.in_valid && !w_inReady) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_matrix_transpose_stream.sv
// ---------------------------------------------------------------------------
// tb_matrix_transpose_stream
// Directed bench for matrix_transpose_stream with DIM=4, DATA_WIDTH=8.
// Input element (r,c) of matrix m is 64*m + 16*r + c. A transposed beat k
// therefore carries 64*m + 16*e + k in slot e, a passthrough beat carries
// 64*m + 16*k + e. Build with MT_STREAM_STATS_EN to also cover the counters.
// ---------------------------------------------------------------------------
module tb_matrix_transpose_stream;

    localparam int DW    = 8;
    localparam int DIM   = 4;
    localparam int ROW_W = DW * DIM;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int errorCount = 0;
    int checkCount = 0;

    int stalls;
    int firstBlock;
    int firstBeat;
    int lastBeat;
    int gaps;
    logic [ROW_W-1:0] firstRowSeen;

    mt_stream_if #(.DATA_WIDTH(DW), .DIM(DIM)) bus ();

`ifdef MT_STREAM_STATS_EN
    logic [31:0] matCount;
    logic [31:0] stallCount;
`endif

    matrix_transpose_stream #(
        .DATA_WIDTH (DW),
        .DIM        (DIM)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus)
`ifdef MT_STREAM_STATS_EN
        ,
        .mat_count   (matCount),
        .stall_count (stallCount)
`endif
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
        end
    endtask

    // Drives all handshake inputs at once.
    task automatic applyStimulus(input logic valid, input logic mode, input logic [ROW_W-1:0] row, input logic ready);
        bus.in_valid  = valid;
        bus.in_mode   = mode;
        bus.in_row    = row;
        bus.out_ready = ready;
    endtask

    // Input row r of matrix m.
    function automatic logic [ROW_W-1:0] makeRow(input int m, input int r);
        logic [ROW_W-1:0] row;
        row = '0;
        for (int c = 0; c < DIM; c++) row[c*DW +: DW] = 8'(64*m + 16*r + c);
        return row;
    endfunction

    // Expected output beat k of matrix m in the given mode.
    function automatic logic [ROW_W-1:0] expBeat(input int m, input int k, input logic mode);
        logic [ROW_W-1:0] row;
        row = '0;
        for (int e = 0; e < DIM; e++) begin
            if (mode) row[e*DW +: DW] = 8'(64*m + 16*e + k);
            else      row[e*DW +: DW] = 8'(64*m + 16*k + e);
        end
        return row;
    endfunction

    task automatic resetDut();
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
    endtask

    // Cycle-by-cycle producer/consumer. Offers nMat matrices back to back
    // (mode of matrix m = modes[m]), holds out_ready low for holdCycles, and
    // checks every presented beat against the model in order.
    task automatic runStream(input int nMat, input logic [7:0] modes, input int holdCycles,
                             input int maxCycles, input string tag);
        int total;
        int rowIdx;
        int beatIdx;
        int cyc;
        int bm;
        int k;
        logic accept;
        total      = nMat * DIM;
        rowIdx     = 0;
        beatIdx    = 0;
        cyc        = 0;
        stalls     = 0;
        firstBlock = -1;
        firstBeat  = -1;
        lastBeat   = -1;
        gaps       = 0;
        while (beatIdx < total && cyc < maxCycles) begin
            if (rowIdx < total)
                applyStimulus(1'b1, modes[rowIdx / DIM], makeRow(rowIdx / DIM, rowIdx % DIM), cyc >= holdCycles);
            else
                applyStimulus(1'b0, 1'b0, '0, cyc >= holdCycles);
            #1;
            accept = bus.in_valid && bus.in_ready;
            if (bus.in_valid && !bus.in_ready) begin
                stalls++;
                if (firstBlock < 0) firstBlock = rowIdx;
            end
            if (bus.out_valid) begin
                bm = beatIdx / DIM;
                k  = beatIdx % DIM;
                checkOutput({tag, "_row"}, bus.out_row, expBeat(bm, k, modes[bm]));
                checkOutput({tag, "_last"}, bus.out_last, (k == DIM - 1));
                checkOutput({tag, "_mode"}, bus.out_mode, modes[bm]);
                if (bus.out_ready) begin
                    if (firstBeat < 0) begin
                        firstBeat    = cyc;
                        firstRowSeen = bus.out_row;
                    end
                    lastBeat = cyc;
                    beatIdx++;
                end
            end else begin
                checkOutput({tag, "_idle"}, {bus.out_row, bus.out_last, bus.out_mode}, '0);
                if (firstBeat >= 0) gaps++;
            end
            if (accept) rowIdx++;
            @(posedge clk); #1;
            cyc++;
        end
        checkOutput({tag, "_all_beats"}, beatIdx, total);
    endtask

    initial begin
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", bus.in_ready, 0);
        checkOutput("rst_out_valid", bus.out_valid, 0);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_in_ready", bus.in_ready, 1);
        checkOutput("post_rst_out_valid", bus.out_valid, 0);

        // Single transposed matrix, free-flowing output.
        runStream(1, 8'b0000_0001, 0, 40, "t1");
        checkOutput("t1_first_beat_cycle", firstBeat, 4);
        checkOutput("t1_beat0_const", firstRowSeen, 32'h3020_1000);

        // Single passthrough matrix.
        runStream(1, 8'b0000_0000, 0, 40, "t2");
        checkOutput("t2_first_beat_cycle", firstBeat, 4);
        checkOutput("t2_beat0_const", firstRowSeen, 32'h0302_0100);

        // Back-pressure: three matrices offered while out_ready is held low.
        resetDut();
        runStream(3, 8'b0000_0101, 11, 80, "bp");
        checkOutput("bp_first_block_row", firstBlock, 8);
        checkOutput("bp_stall_cycles", stalls, 7);
        checkOutput("bp_first_beat_cycle", firstBeat, 11);
`ifdef MT_STREAM_STATS_EN
        checkOutput("stat_mat_count", matCount, 3);
        checkOutput("stat_stall_count", stallCount, stalls);
`endif

        // Continuous streaming with alternating modes.
        runStream(4, 8'b0000_1010, 0, 80, "st");
        checkOutput("st_first_beat_cycle", firstBeat, 4);
        checkOutput("st_last_beat_cycle", lastBeat, 19);
        checkOutput("st_gaps", gaps, 0);
        checkOutput("st_stalls", stalls, 0);

        // Reset in the middle of filling a matrix discards it.
        for (int r = 0; r < 3; r++) begin
            applyStimulus(1'b1, 1'b1, makeRow(0, r), 1'b1);
            @(posedge clk); #1;
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        rst = 1'b1;
        #1;
        checkOutput("mr_rst_in_ready", bus.in_ready, 0);
        checkOutput("mr_rst_out_valid", bus.out_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checkOutput("mr_post_in_ready", bus.in_ready, 1);
        for (int i = 0; i < 3; i++) begin
            checkOutput("mr_out_valid_low", bus.out_valid, 0);
            @(posedge clk); #1;
        end
        runStream(1, 8'b0000_0001, 0, 40, "mr");
        checkOutput("mr_first_beat_cycle", firstBeat, 4);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/matrix_transpose_stream.md
Name: matrix_transpose_stream

Overview:
- Streaming, double-buffered DIM x DIM matrix transpose engine with valid/ready handshakes on both sides.
- Accepts one matrix row per beat into a ping-pong register bank. Emits that matrix one beat per output transfer, either transposed (columns) or unchanged (rows), selected per matrix.
- Sits between the memory-group fabric and the PE array. Replaces a fixed single-cycle transpose register that had no flow control.

Parameters:
- DATA_WIDTH, 64, width of one element in bits.
- DIM, 8, matrix dimension; rows, columns and elements per beat. Must be >= 2.
- CNT_W, $clog2(DIM), localparam, width of row/beat counters.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  input row valid
- in_ready  output  1  block can accept a row
- in_mode  input  1  0 = passthrough, 1 = transpose; sampled on the first row of each matrix only
- in_row  input  DIM*DATA_WIDTH  row elements; element e at bits [e*DATA_WIDTH +: DATA_WIDTH]
- out_valid  output  1  output beat valid
- out_ready  input  1  downstream accepts beat
- out_row  output  DIM*DATA_WIDTH  output beat, same element packing as in_row
- out_last  output  1  high on the final beat (beat DIM-1) of a matrix
- out_mode  output  1  mode of the matrix currently being drained

Behaviour:
- Storage and pointers
  - Two banks, B0 and B1, each DIM x DIM elements.
  - Per-bank full flag and per-bank mode bit.
  - Write pointer wb, read pointer rb, write row counter wr_cnt, read beat counter rd_cnt.
- Reset (rst high at posedge)
  - Full flags, wb, rb, wr_cnt and rd_cnt all cleared to 0.
  - Bank contents are not reset.
  - A partially written or partially drained matrix is discarded.
  - in_ready = 0 while rst is high. In the first cycle after reset, in_ready = 1 and out_valid = 0.
- Input side
  - in_ready = !rst && !full[wb].
  - A row is accepted when in_valid && in_ready. It is written to bank[wb] row wr_cnt.
  - If wr_cnt == 0, in_mode is also latched into mode[wb].
  - If wr_cnt == DIM-1: set full[wb], toggle wb, clear wr_cnt. Otherwise increment wr_cnt.
- Output side
  - out_valid = full[rb].
  - Transpose mode: out_row element e = bank[rb][e][rd_cnt], i.e. column rd_cnt.
  - Passthrough mode: out_row element e = bank[rb][rd_cnt][e], i.e. row rd_cnt.
  - When out_valid = 0, out_row = 0, out_last = 0 and out_mode = 0.
  - out_last = out_valid && (rd_cnt == DIM-1). out_mode = mode[rb].
  - A beat is transferred when out_valid && out_ready.
  - On the last beat: clear full[rb], toggle rb, clear rd_cnt. Otherwise increment rd_cnt.
  - out_row, out_last and out_mode hold stable while out_valid && !out_ready.
- Latency and throughput
  - The first beat of a matrix is valid the cycle after its last row is accepted.
  - Sustained throughput is one row in and one beat out per cycle, with no bubbles between matrices.
- Boundary conditions
  - Both banks full: in_ready = 0 until the draining bank releases.
  - A bank is released at the posedge of its last output transfer. in_ready may rise in the following cycle only; there is no same-cycle bypass.
  - Simultaneous write completion on bank[wb] and read completion on bank[rb]: both take effect. wb != rb holds whenever both banks are active.
  - in_mode is ignored on rows 1..DIM-1.
  - in_valid with in_ready = 0: no state change. The row is held by upstream.

Optional Feature:
- Macro MT_STREAM_STATS_EN.
- Defined:
  - Adds output ports mat_count[31:0], the number of matrices fully drained (incremented on the out_last transfer).
  - Adds stall_count[31:0], the number of cycles with in_valid && !in_ready.
  - Both counters clear on rst and wrap at 2^32.
- Undefined: the ports and the logic are absent. All other behaviour is identical.

Decomposition:
- Package mt_pkg:
  - typedef mt_mode_e {MT_PASS = 1'b0, MT_TRANSPOSE = 1'b1}.
  - Function mt_elem(row, e) to slice element e from a packed row.
- Sub-module mt_bank (parameters DATA_WIDTH, DIM):
  - One DIM x DIM storage array.
  - Write-enable and row-index write port.
  - Read index plus mode input, producing a combinational row or column read mux.
- The top level instantiates two mt_bank instances and contains all pointers, flags and handshake logic.

Test Plan (DIM=4, DATA_WIDTH=8, in element r,c = 16*r+c):
- Transpose, one matrix, out_ready=1:
  - Rows accepted on cycles 0-3.
  - out_valid rises on cycle 4.
  - Beat 0 = {0x30,0x20,0x10,0x00} (element 0 in the LSBs).
  - out_last is high on beat 3 only.
- Passthrough matrix: beats equal the input rows in order, and out_mode = 0.
- Back-pressure:
  - out_ready=0 while three matrices are offered.
  - Two matrices are accepted, then in_ready=0 on the 9th row attempt. The matrix 0 first beat stays stable.
  - Raise out_ready: all 12 beats of the three matrices are emitted in order with correct modes.
- Streaming: continuous in_valid/out_ready over 4 matrices with alternating modes produces 16 consecutive output beats with no gaps after the first.
- Mid-operation reset: pulse rst after row 2 of matrix 0. out_valid stays 0; a fresh matrix then transposes correctly.
- MT_STREAM_STATS_EN: after the back-pressure test, mat_count = 3 and stall_count equals the counted cycles with in_valid && !in_ready.
